// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and tap indexing for the 3x3 window block.
package conv_pkg;
   localparam int DATA_W  = 64;
   localparam int DIM_W   = 9;
   localparam int MIN_DIM = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Flat tap number of window position (r,c); r=0 top/oldest row, c=0 leftmost/oldest column.
   function automatic int tap_idx(input int r, input int c);
      return 3 * r + c;
   endfunction
endpackage

// File: rtl/conv_window3x3_if.sv
// Pixel-in / window-out bundle between the line-buffer front end and the MAC array.
interface conv_window3x3_if
   import conv_pkg::*;
#(
   parameter int DataWidth = DATA_W,
   parameter int DimWidth  = DIM_W
);
   logic                   start;
   logic [DimWidth-1:0]    img_width;
   logic [DimWidth-1:0]    img_height;
   logic                   in_valid;
   logic [DataWidth-1:0]   din_row0;
   logic [DataWidth-1:0]   din_row1;
   logic [DataWidth-1:0]   din_row2;
   logic [DimWidth-1:0]    line_len;
   logic                   win_valid;
   logic [9*DataWidth-1:0] win;
   logic [DimWidth-1:0]    win_row;
   logic [DimWidth-1:0]    win_col;
   logic                   frame_done;
   logic                   err;

   modport master (
      output start, img_width, img_height, in_valid, din_row0, din_row1, din_row2,
      input  line_len, win_valid, win, win_row, win_col, frame_done, err
   );

   modport slave (
      input  start, img_width, img_height, in_valid, din_row0, din_row1, din_row2,
      output line_len, win_valid, win, win_row, win_col, frame_done, err
   );
endinterface

// File: rtl/win_row_shift.sv
// One window row: three taps shifting toward tap 0 (oldest) when enabled.
module win_row_shift #(
   parameter int DataWidth = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [DataWidth-1:0]      din,
   output logic [2:0][DataWidth-1:0] taps
);
   always_ff @(posedge clk) begin
      if (rst) begin
         taps <= '0;
      end else if (en) begin
         taps[0] <= taps[1];
         taps[1] <= taps[2];
         taps[2] <= din;
      end
   end
endmodule

// File: rtl/conv_window3x3.sv
// 3x3 sliding window over a raster stream plus its two line-delayed copies.
// Registered outputs, one pixel per cycle, one-cycle latency, no backpressure.
module conv_window3x3
   import conv_pkg::*;
#(
   parameter int DataWidth = DATA_W,
   parameter int DimWidth  = DIM_W
) (
   input logic            clk,
   input logic            rst,
   conv_window3x3_if.slave bus
);
   localparam logic [DimWidth-1:0] ONE   = DimWidth'(1);
   localparam logic [DimWidth-1:0] TWO   = DimWidth'(2);
   localparam logic [DimWidth-1:0] MIN_D = DimWidth'(MIN_DIM);

   state_t                state;
   logic [DimWidth-1:0]   width;
   logic [DimWidth-1:0]   height;
   logic [DimWidth-1:0]   col;
   logic [DimWidth-1:0]   row;
   logic                  win_valid;
   logic [DimWidth-1:0]   win_row;
   logic [DimWidth-1:0]   win_col;
   logic                  frame_done;
   logic                  err;
   logic                  shift_en;
   logic [2:0][DataWidth-1:0] taps [3];

   assign shift_en = (state == ACTIVE) && bus.in_valid;

   // Window row 0 is the oldest line, so it is fed from the twice-delayed stream.
   win_row_shift #(.DataWidth(DataWidth)) u_top (
      .clk(clk), .rst(rst), .en(shift_en), .din(bus.din_row2), .taps(taps[0])
   );
   win_row_shift #(.DataWidth(DataWidth)) u_mid (
      .clk(clk), .rst(rst), .en(shift_en), .din(bus.din_row1), .taps(taps[1])
   );
   win_row_shift #(.DataWidth(DataWidth)) u_bot (
      .clk(clk), .rst(rst), .en(shift_en), .din(bus.din_row0), .taps(taps[2])
   );

   for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
         assign bus.win[tap_idx(r, c)*DataWidth +: DataWidth] = taps[r][c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         width      <= '0;
         height     <= '0;
         col        <= '0;
         row        <= '0;
         win_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.img_width < MIN_D || bus.img_height < MIN_D) begin
                     err <= 1'b1;
                  end else begin
                     width  <= bus.img_width;
                     height <= bus.img_height;
                     col    <= '0;
                     row    <= '0;
                     state  <= ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               if (!bus.in_valid) begin
                  // A gap desynchronises the external line buffers; the frame is unrecoverable.
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  if (row >= TWO && col >= TWO) begin
                     win_valid <= 1'b1;
                     win_row   <= row - TWO;
                     win_col   <= col - TWO;
                  end
                  if (col == width - ONE) begin
                     col <= '0;
                     row <= row + ONE;
                     if (row == height - ONE) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                     end
                  end else begin
                     col <= col + ONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.line_len   = width;
   assign bus.win_valid  = win_valid;
   assign bus.win_row    = win_row;
   assign bus.win_col    = win_col;
   assign bus.frame_done = frame_done;
   assign bus.err        = err;
endmodule

// File: tb/tb_conv_window3x3.sv
// Directed bench for conv_window3x3; line buffers are modelled as ideal W/2W pixel delays.
module tb_conv_window3x3;
   import conv_pkg::*;

   typedef logic [575:0] val_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   nwin;
   int   ndone;
   int   pix_idx;
   int   first_k;
   val_t first_win;
   val_t last_win;
   val_t hand_win;

   conv_window3x3_if cw ();

   conv_window3x3 dut (
      .clk(clk),
      .rst(rst),
      .bus(cw.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input val_t got, input val_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pix(input int r, input int c);
      if (r < 0) return 64'h0;
      return 64'(16 * r + c);
   endfunction

   function automatic val_t win_exp(input int r, input int c);
      val_t v;
      v = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            v[(3*i+j)*64 +: 64] = pix(r - 2 + i, c - 2 + j);
      return v;
   endfunction

   task automatic clear_stats();
      nwin    = 0;
      ndone   = 0;
      pix_idx = 0;
      first_k = -1;
   endtask

   task automatic do_start(input int w, input int h);
      cw.start      = 1'b1;
      cw.img_width  = 9'(w);
      cw.img_height = 9'(h);
      @(posedge clk);
      #1;
      cw.start = 1'b0;
   endtask

   task automatic pixel_cycle(input int r, input int c, input int w, input int h, input bit live);
      bit exp_v;
      bit exp_d;
      cw.in_valid = 1'b1;
      cw.din_row0 = pix(r, c);
      cw.din_row1 = pix(r - 1, c);
      cw.din_row2 = pix(r - 2, c);
      @(posedge clk);
      #1;
      cw.in_valid = 1'b0;
      exp_v = live && r >= 2 && c >= 2;
      exp_d = live && r == h - 1 && c == w - 1;
      check("win_valid", val_t'(cw.win_valid), val_t'(exp_v));
      check("frame_done", val_t'(cw.frame_done), val_t'(exp_d));
      check("err_quiet", val_t'(cw.err), val_t'(1'b0));
      if (exp_v) begin
         check("win_taps", cw.win, win_exp(r, c));
         check("win_row", val_t'(cw.win_row), val_t'(r - 2));
         check("win_col", val_t'(cw.win_col), val_t'(c - 2));
      end
      if (cw.win_valid) begin
         if (nwin == 0) begin
            first_k   = pix_idx;
            first_win = cw.win;
         end
         nwin++;
         last_win = cw.win;
      end
      if (cw.frame_done) ndone++;
      pix_idx++;
   endtask

   task automatic run_frame(input int w, input int h);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            pixel_cycle(r, c, w, h, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_win_valid"}, val_t'(cw.win_valid), val_t'(1'b0));
      check({tag, "_win"}, cw.win, val_t'(0));
      check({tag, "_line_len"}, val_t'(cw.line_len), val_t'(0));
      check({tag, "_win_row"}, val_t'(cw.win_row), val_t'(0));
      check({tag, "_win_col"}, val_t'(cw.win_col), val_t'(0));
      check({tag, "_frame_done"}, val_t'(cw.frame_done), val_t'(0));
      check({tag, "_err"}, val_t'(cw.err), val_t'(0));
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      cw.start      = 1'b0;
      cw.img_width  = '0;
      cw.img_height = '0;
      cw.in_valid   = 1'b0;
      cw.din_row0   = '0;
      cw.din_row1   = '0;
      cw.din_row2   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Basic 5x4 frame, then 7x3 started in the cycle frame_done is visible.
      clear_stats();
      do_start(5, 4);
      check("b_line_len", val_t'(cw.line_len), val_t'(5));
      check("b_start_err", val_t'(cw.err), val_t'(0));
      run_frame(5, 4);
      check("b_nwin", val_t'(nwin), val_t'(6));
      check("b_ndone", val_t'(ndone), val_t'(1));
      check("b_first_cycle", val_t'(first_k + 1), val_t'(13));
      hand_win = {64'h22, 64'h21, 64'h20, 64'h12, 64'h11, 64'h10, 64'h02, 64'h01, 64'h00};
      check("b_first_win", first_win, hand_win);
      hand_win = {64'h34, 64'h33, 64'h32, 64'h24, 64'h23, 64'h22, 64'h14, 64'h13, 64'h12};
      check("b_last_win", last_win, hand_win);

      clear_stats();
      do_start(7, 3);
      check("b2b_line_len", val_t'(cw.line_len), val_t'(7));
      run_frame(7, 3);
      check("b2b_nwin", val_t'(nwin), val_t'(5));
      check("b2b_ndone", val_t'(ndone), val_t'(1));

      // Reset after 10 pixels of a 5-wide frame.
      clear_stats();
      do_start(5, 4);
      for (int k = 0; k < 10; k++) pixel_cycle(k / 5, k % 5, 5, 4, 1'b1);
      cw.in_valid = 1'b1;
      cw.din_row0 = pix(2, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("midrst");
      rst         = 1'b0;
      cw.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_all_zero("postrst");

      // Minimum 3x3 frame.
      clear_stats();
      do_start(3, 3);
      run_frame(3, 3);
      check("min_nwin", val_t'(nwin), val_t'(1));
      check("min_ndone", val_t'(ndone), val_t'(1));
      check("min_centre", val_t'(last_win[4*64 +: 64]), val_t'(64'h11));

      // Illegal width.
      do_start(2, 5);
      check("ill_err", val_t'(cw.err), val_t'(1));
      check("ill_line_len", val_t'(cw.line_len), val_t'(3));
      clear_stats();
      for (int k = 0; k < 4; k++) pixel_cycle(2, k, 3, 3, 1'b0);
      check("ill_line_len_hold", val_t'(cw.line_len), val_t'(3));
      @(posedge clk);
      #1;
      check("ill_idle_no_err", val_t'(cw.err), val_t'(0));

      // Input gap at pixel (2,3) of a 5x4 frame.
      clear_stats();
      do_start(5, 4);
      begin
         bit live;
         live = 1'b1;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
               if (r == 2 && c == 3) begin
                  cw.in_valid = 1'b0;
                  @(posedge clk);
                  #1;
                  check("gap_err", val_t'(cw.err), val_t'(1));
                  check("gap_win_valid", val_t'(cw.win_valid), val_t'(0));
                  live = 1'b0;
               end else begin
                  pixel_cycle(r, c, 5, 4, live);
               end
            end
         end
      end
      check("gap_nwin", val_t'(nwin), val_t'(1));
      check("gap_ndone", val_t'(ndone), val_t'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
